div: RTL and testbench
======================

Name: div

Overview:
- Iterative 32-bit radix-2 restoring divider serving the execute stage. It consumes the operand pair that the ID/EX register delivers to EX for DIV/DIVU.
- EX raises start, holds operands stable, and asserts a pipeline stall request while ready_o is low.
- On completion the block returns the quotient and remainder to EX for the HI/LO write path.
- One division per handshake; annul cancels on flush.

Parameters:
- DATA_W, 32, operand width; the only supported value is 32.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-low; rst==0 sampled at a rising edge resets the block.
- signed_div_i  input  1  1 = DIV (signed), 0 = DIVU (unsigned).
- opdata1_i  input  32  dividend.
- opdata2_i  input  32  divisor.
- start_i  input  1  request; held high by EX until ready_o is seen.
- annul_i  input  1  cancel the current operation (pipeline flush).
- result_o  output  64  {remainder[63:32], quotient[31:0]}.
- ready_o  output  1  result valid; high only in state END.

Behaviour:
- Reset (rst==0 at clock edge): state FREE, cnt=0, result_o=0, ready_o=0. Reset overrides start_i and annul_i, including mid-division.
- State FREE:
  - result_o=0, ready_o=0.
  - start_i=1 and annul_i=0: if opdata2_i==0, go to BYZERO; otherwise go to ON.
  - On entry to ON: cnt=0; latch abs(dividend)/abs(divisor) when signed_div_i=1, raw values otherwise; latch both sign bits and the mode.
  - start_i=1 and annul_i=1: stay in FREE.
- State BYZERO: next cycle go to END with result 0.
- State ON, cnt<32:
  - One step per cycle: 33-bit trial subtraction of the divisor from the partial remainder.
  - Non-negative: shift in quotient bit 1 and keep the difference. Negative: shift in 0 and keep the partial remainder.
  - cnt+1.
- State ON, cnt==32 (finalize):
  - Signed mode: negate the quotient if the latched signs differ; negate the remainder if the dividend was negative.
  - Go to END.
- State END:
  - ready_o=1; result_o holds the final value.
  - Stay while start_i=1. When start_i=0, go to FREE next cycle with ready_o=0 and result_o=0.
- annul_i=1 in ON, BYZERO or END: next state FREE, ready_o=0, result_o=0, no result delivered.
- Latency, with start sampled at edge N:
  - Normal: ON for edges N+1..N+33, ready_o high from edge N+34.
  - Divide-by-zero: ready_o high from edge N+2.
- Operands are sampled only in FREE; changes while busy are ignored.
- Edge cases:
  - 0x80000000 / 0xFFFFFFFF signed yields quotient 0x80000000, remainder 0. No trap.
  - Dividend 0 runs the full 33 ON cycles and gives result 0.
- start_i held high continuously: after END → FREE (needs start_i=0), no new operation begins until start_i is low for at least one cycle.
- result_o and ready_o are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro DIV_ZERO_FLAG_EN.
- Defined: extra output div_zero_o (1 bit), registered. It is 1 exactly while in END when the operation came through BYZERO, and 0 otherwise, including at reset.
- Undefined: port absent. Divide-by-zero is distinguishable only by result 0 and the 2-cycle latency.

Test Plan:
1. Unsigned: signed_div_i=0, opdata1=100, opdata2=7, start held -> ready_o rises exactly 34 cycles later; result_o={32'd2, 32'd14}. Drop start -> ready_o=0, result_o=0 next cycle.
2. Signed: opdata1=0xFFFFFFF9 (-7), opdata2=2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also 7 / 0xFFFFFFFE -> quotient 0xFFFFFFFD, remainder 1.
3. Divide by zero: opdata1=0x1234, opdata2=0 -> ready_o after 2 cycles, result_o=0. With DIV_ZERO_FLAG_EN, div_zero_o=1 in the same cycle.
4. Annul: start 100/7, assert annul_i for 1 cycle at cycle 10 -> FREE next cycle, ready_o never asserts. A fresh start of 9/3 then gives quotient 3, remainder 0 at the normal latency.
5. Overflow corner: signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0. Unsigned 0xFFFFFFFF / 1 -> quotient 0xFFFFFFFF, remainder 0.
6. Reset mid-operation: rst=0 at cycle 20 of a division -> next edge result_o=0, ready_o=0, state FREE. After rst=1, a new request completes normally.

Source files
------------

// File: rtl/div.sv
// div: iterative radix-2 restoring divider for the EX stage (DIV/DIVU)
//
// Ports:
//   clk           pipeline clock, all state updates on the rising edge
//   rst           synchronous reset, active-low
//   signed_div_i  1 = signed divide (DIV), 0 = unsigned divide (DIVU)
//   opdata1_i     dividend, sampled only when a request is accepted
//   opdata2_i     divisor, sampled only when a request is accepted
//   start_i       request, held high by EX until ready_o is seen
//   annul_i       cancels the operation in flight (pipeline flush)
//   result_o      {remainder, quotient}, registered, zero unless ready_o
//   ready_o       result valid, registered
//   div_zero_o    present only with DIV_ZERO_FLAG_EN: the result on
//                 result_o came from a divide-by-zero request
//
// Optional build macro: DIV_ZERO_FLAG_EN adds div_zero_o.
module div #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o
`ifdef DIV_ZERO_FLAG_EN
   ,output logic                div_zero_o
`endif
);

    typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;

    state_t              r_state, w_state;
    logic [5:0]          r_cnt, w_cnt;
    logic [DATA_W-1:0]   r_rem, w_rem;
    logic [DATA_W-1:0]   r_q, w_q;
    logic [DATA_W-1:0]   r_dvs, w_dvs;
    logic                r_s1, w_s1, r_s2, w_s2, r_sgn, w_sgn;
    logic [2*DATA_W-1:0] r_result, w_result;
    logic                r_ready, w_ready;
    logic [DATA_W:0]     w_trial;
    logic [DATA_W-1:0]   w_qf, w_rf;

    // The partial remainder is always below the divisor, so the shifted
    // value fits in 33 bits and the MSB of the 33-bit difference is its sign.
    assign w_trial = {r_rem, r_q[DATA_W-1]} - {1'b0, r_dvs};
    assign w_qf    = (r_sgn && (r_s1 ^ r_s2)) ? -r_q : r_q;
    assign w_rf    = (r_sgn && r_s1) ? -r_rem : r_rem;

    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_rem    = r_rem;
        w_q      = r_q;
        w_dvs    = r_dvs;
        w_s1     = r_s1;
        w_s2     = r_s2;
        w_sgn    = r_sgn;
        w_result = '0;
        w_ready  = 1'b0;
        case (r_state)
            S_FREE: begin
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        w_state = S_BYZERO;
                    end else begin
                        w_state = S_ON;
                        w_cnt   = '0;
                        w_rem   = '0;
                        w_q     = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
                        w_dvs   = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
                        w_s1    = opdata1_i[DATA_W-1];
                        w_s2    = opdata2_i[DATA_W-1];
                        w_sgn   = signed_div_i;
                    end
                end
            end
            S_BYZERO: begin
                w_state = annul_i ? S_FREE : S_END;
                w_ready = !annul_i;
            end
            S_ON: begin
                if (annul_i) begin
                    w_state = S_FREE;
                end else if (r_cnt == 6'(DATA_W)) begin
                    w_state  = S_END;
                    w_ready  = 1'b1;
                    w_result = {w_rf, w_qf};
                end else begin
                    w_cnt = r_cnt + 6'd1;
                    w_q   = {r_q[DATA_W-2:0], !w_trial[DATA_W]};
                    w_rem = w_trial[DATA_W] ? {r_rem[DATA_W-2:0], r_q[DATA_W-1]} : w_trial[DATA_W-1:0];
                end
            end
            S_END: begin
                w_state  = (annul_i || !start_i) ? S_FREE : S_END;
                w_ready  = w_state == S_END;
                w_result = w_ready ? r_result : '0;
            end
            default: w_state = S_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_FREE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_q      <= '0;
            r_dvs    <= '0;
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_sgn    <= 1'b0;
            r_result <= '0;
            r_ready  <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_rem    <= w_rem;
            r_q      <= w_q;
            r_dvs    <= w_dvs;
            r_s1     <= w_s1;
            r_s2     <= w_s2;
            r_sgn    <= w_sgn;
            r_result <= w_result;
            r_ready  <= w_ready;
        end
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;

`ifdef DIV_ZERO_FLAG_EN
    logic r_zero;

    // Set on BYZERO -> END and held only while END persists.
    always_ff @(posedge clk) begin
        if (!rst)
            r_zero <= 1'b0;
        else
            r_zero <= (w_state == S_END) && ((r_state == S_BYZERO) || r_zero);
    end

    assign div_zero_o = r_zero;
`endif

endmodule

// File: tb/tb_div.sv
// tb_div: directed self-checking bench for div
module tb_div;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sgn = 1'b0;
    logic        start = 1'b0;
    logic        annul = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [63:0] res;
    logic        rdy;
`ifdef DIV_ZERO_FLAG_EN
    logic        dz;
`endif
    int n_chk = 0;
    int n_fail = 0;
    logic seen;

    always #5 clk = ~clk;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (sgn),
        .opdata1_i    (a),
        .opdata2_i    (b),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (res),
        .ready_o      (rdy)
`ifdef DIV_ZERO_FLAG_EN
       ,.div_zero_o   (dz)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Counts edges from the one that samples start (inclusive) until ready_o is seen.
    task automatic run(input string tag, input logic s, input logic [31:0] x, input logic [31:0] y,
                       input int lat, input logic [63:0] exp);
        int c = 0;
        sgn = s;
        a = x;
        b = y;
        start = 1'b1;
        do begin
            tick();
            c++;
        end while (!rdy && c < 60);
        check({tag, " latency"}, 64'(c), 64'(lat));
        check({tag, " result"}, res, exp);
`ifdef DIV_ZERO_FLAG_EN
        check({tag, " div_zero"}, 64'(dz), 64'(lat == 2));
`endif
        start = 1'b0;
        tick();
        check({tag, " ready drop"}, 64'(rdy), 64'd0);
        check({tag, " result clear"}, res, 64'd0);
    endtask

    initial begin
        repeat (2) tick();
        check("reset ready", 64'(rdy), 64'd0);
        check("reset result", res, 64'd0);
`ifdef DIV_ZERO_FLAG_EN
        check("reset div_zero", 64'(dz), 64'd0);
`endif
        rst = 1'b1;
        tick();

        run("u 100/7", 1'b0, 32'd100, 32'd7, 34, {32'd2, 32'd14});
        run("s -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 34, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run("s 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 34, {32'd1, 32'hFFFF_FFFD});
        run("s -100/-7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 34, {32'hFFFF_FFFE, 32'd14});
        run("u 0xFFFFFFF9/2", 1'b0, 32'hFFFF_FFF9, 32'd2, 34, {32'd1, 32'h7FFF_FFFC});
        run("div by zero", 1'b0, 32'h1234, 32'd0, 2, 64'd0);
        run("s min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 34, {32'd0, 32'h8000_0000});
        run("u max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 34, {32'd0, 32'hFFFF_FFFF});
        run("zero dividend", 1'b0, 32'd0, 32'd5, 34, 64'd0);

        // Operands changed while busy are ignored; start held keeps END.
        sgn = 1'b0;
        a = 32'd100;
        b = 32'd7;
        start = 1'b1;
        tick();
        a = 32'd5;
        b = 32'd0;
        sgn = 1'b1;
        repeat (33) tick();
        check("busy operands ignored", res, {32'd2, 32'd14});
        tick();
        check("held start ready", 64'(rdy), 64'd1);
        check("held start result", res, {32'd2, 32'd14});
        start = 1'b0;
        tick();
        check("held release ready", 64'(rdy), 64'd0);

        // Annul mid-division.
        sgn = 1'b0;
        a = 32'd100;
        b = 32'd7;
        start = 1'b1;
        repeat (10) tick();
        annul = 1'b1;
        tick();
        check("annul ready", 64'(rdy), 64'd0);
        check("annul result", res, 64'd0);
        annul = 1'b0;
        start = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            tick();
            seen = seen | rdy;
        end
        check("annul no ready", 64'(seen), 64'd0);
        run("after annul 9/3", 1'b0, 32'd9, 32'd3, 34, {32'd0, 32'd3});

        // Start with annul in FREE never begins an operation.
        a = 32'd9;
        b = 32'd3;
        start = 1'b1;
        annul = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            tick();
            seen = seen | rdy;
        end
        check("annul in free", 64'(seen), 64'd0);
        start = 1'b0;
        annul = 1'b0;
        tick();

        // Reset mid-division.
        a = 32'd100;
        b = 32'd7;
        start = 1'b1;
        repeat (20) tick();
        rst = 1'b0;
        tick();
        check("mid reset ready", 64'(rdy), 64'd0);
        check("mid reset result", res, 64'd0);
        start = 1'b0;
        rst = 1'b1;
        tick();
        run("after reset 100/7", 1'b0, 32'd100, 32'd7, 34, {32'd2, 32'd14});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
